injector_ctrl: RTL
==================

# injector_ctrl

Digital controller that drives the bias-generator/signal-injector analog block. It loads the 4-bit pull-up and pull-down trim codes through a valid/ready handshake and produces a clean posedge `latch` for them. On command it enables the injector and streams a programmable square-wave or PRBS7 pattern on `inj_signal` for a fixed or unbounded number of bit periods. It sits between the user-project register file and the injector macro.

## Interface
Parameters:
- `DIV_W`, 16: width of bit-period divider.
- `LEN_W`, 8: width of burst length.
- `SETTLE_CYC`, 16: cycles between enable rising and the first pattern bit (≥1).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  high only in IDLE.
- `cfg_trim_p`  in  4  pull-up trim code.
- `cfg_trim_n`  in  4  pull-down trim code.
- `cfg_mode`  in  2  0 square, 1 PRBS7, 2 constant 1, 3 constant 0.
- `cfg_div`  in  DIV_W  bit period = `cfg_div`+1 cycles.
- `cfg_len`  in  LEN_W  bits per burst; 0 = continuous until `stop`.
- `start`  in  1  begin burst (IDLE only).
- `stop`  in  1  abort burst.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse on normal burst completion.
- `inj_enable`, `inj_latch`, `inj_signal`  out  1 each  to injector.
- `inj_trim_p`, `inj_trim_n`  out  4 each  to injector.

## Operation
- All outputs registered. Reset: state IDLE, all outputs 0 except `cfg_ready`=1; mode/div/len registers 0; LFSR = 7'h7F.
- States: IDLE, LOAD, LATCH, SETTLE, RUN, DONE.
- IDLE: `cfg_valid`&`cfg_ready` captures all cfg fields → LOAD. Else `start` → SETTLE. Both same cycle: config wins, `start` dropped. `stop` in IDLE ignored.
- LOAD (1 cycle): `inj_trim_*` take new codes, `inj_latch`=0 → LATCH.
- LATCH (2 cycles): `inj_latch`=1, trims held → IDLE (`inj_latch` returns 0). Trim outputs change only in LOAD.
- SETTLE: `inj_enable`=1, `inj_signal`=0, count `SETTLE_CYC` cycles → RUN. LFSR reseeded to 7'h7F, bit counter cleared on entry.
- RUN: each bit held `cfg_div`+1 cycles. Square: first bit 1, toggles per bit. PRBS7: x^7+x^6+1, output = lfsr[6], shift at end of each bit. Modes 2/3 constant. Bit counter increments per completed bit, saturates in continuous mode; when it equals `cfg_len` (≠0) → DONE.
- DONE (1 cycle): `done`=1, `inj_enable`=0, `inj_signal`=0 → IDLE.
- `stop` in SETTLE/RUN: next cycle IDLE, `inj_enable`/`inj_signal`=0, no `done`. `stop` coincident with last bit end: stop wins.
- `stop` in LOAD/LATCH ignored (latch sequence always completes).

## Timing
- `cfg_valid` accepted at edge t → trims change at t+1, `inj_latch` high t+2..t+3, `cfg_ready` high again at t+4.
- `start` sampled at edge t → `inj_enable`=1 from t+1; first bit on `inj_signal` at t+1+`SETTLE_CYC`.
- Burst with len N, div D: RUN lasts N·(D+1) cycles; `done` and `inj_enable` fall at same cycle immediately after.
- `cfg_div`=0: new bit every cycle.
- Reset assertion mid-burst: outputs drop to reset values asynchronously.

## Structure
- Package `injector_pkg`: state enum, mode codes, PRBS seed 7'h7F and tap positions, latch width (2).
- Sub-module `injector_patgen`: bit timer, bit counter, square/LFSR generator; inputs mode/div/len/run/clear, outputs bit and `last_bit`. FSM stays in `injector_ctrl`.

## Test plan
- Reset: all outputs 0, `cfg_ready`=1; load trim_p=4'hA, trim_n=4'h3 → trims change at t+1, `inj_latch` high exactly 2 cycles, trims stable throughout.
- Square, div=3, len=4: `inj_signal` 1,0,1,0 each 4 cycles, `done` pulse 16 cycles after RUN entry, enable falls with `done`.
- PRBS7, div=0, len=0: 254 cycles of output repeat with period 127 and match reference LFSR from seed 7'h7F; `stop` → enable 0 next cycle, no `done`.
- `cfg_valid` and `start` same IDLE cycle: config loaded, no burst; `start` during RUN ignored.
- `stop` on final bit-end cycle: no `done`; `rst_n` low mid-RUN: outputs 0 immediately, trims 0.

Source files
------------

// File: rtl/injector_pkg.sv
// Shared types and constants for the injector controller and its pattern generator.
package injector_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LATCH,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_PRBS   = 2'd1,
    MODE_ONE    = 2'd2,
    MODE_ZERO   = 2'd3
  } mode_t;

  // PRBS7, polynomial x^7 + x^6 + 1, Fibonacci form, output taken from the MSB
  localparam logic [6:0]  PRBS_SEED   = 7'h7F;
  localparam int unsigned PRBS_TAP_HI = 6;
  localparam int unsigned PRBS_TAP_LO = 5;

  // Number of cycles inj_latch is held high after new trims are presented
  localparam int unsigned LATCH_CYC = 2;

  function automatic logic [6:0] prbs_step(input logic [6:0] s);
    return {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/injector_patgen.sv
// Bit-period timer, burst bit counter and square/PRBS7/constant pattern source.
module injector_patgen
  import injector_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  mode_t            mode,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] len,
  input  logic             run,
  input  logic             clear,
  output logic             pat_bit,
  output logic             last_bit
);

  logic [DIV_W-1:0] timer;
  logic [LEN_W-1:0] count;
  logic [6:0]       lfsr;
  logic             sq;
  logic             bit_end;

  assign bit_end  = run && (timer == div);
  // Final bit of a bounded burst is ending this cycle
  assign last_bit = bit_end && (len != '0) && (count == len - 1'b1);

  // Timer, bit counter (saturating) and generator state advance at each bit end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      count <= '0;
      lfsr  <= PRBS_SEED;
      sq    <= 1'b1;
    end else if (clear) begin
      timer <= '0;
      count <= '0;
      lfsr  <= PRBS_SEED;
      sq    <= 1'b1;
    end else if (run) begin
      if (bit_end) begin
        timer <= '0;
        if (count != '1) count <= count + 1'b1;
        lfsr  <= prbs_step(lfsr);
        sq    <= ~sq;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Current pattern bit selected by mode
  always_comb begin
    pat_bit = 1'b0;
    unique case (mode)
      MODE_SQUARE: pat_bit = sq;
      MODE_PRBS:   pat_bit = lfsr[6];
      MODE_ONE:    pat_bit = 1'b1;
      MODE_ZERO:   pat_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/injector_ctrl.sv
// Trim-load / latch sequencer and burst controller for the bias-generator injector.
module injector_ctrl
  import injector_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_trim_p,
  input  logic [3:0]       cfg_trim_n,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             inj_enable,
  output logic             inj_latch,
  output logic             inj_signal,
  output logic [3:0]       inj_trim_p,
  output logic [3:0]       inj_trim_n
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned LAT_W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  state_t           state, next_state;
  mode_t            mode_q;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] len_q;
  logic [3:0]       trim_p_q, trim_n_q;
  logic [SET_W-1:0] settle_cnt;
  logic [LAT_W-1:0] latch_cnt;
  logic             accept, settle_end, latch_end;
  logic             pat_bit, last_bit;

  assign accept     = (state == S_IDLE) && cfg_valid && cfg_ready;
  assign settle_end = (settle_cnt == SET_W'(SETTLE_CYC - 1));
  assign latch_end  = (latch_cnt == LAT_W'(LATCH_CYC - 1));

  injector_patgen #(
    .DIV_W (DIV_W),
    .LEN_W (LEN_W)
  ) u_patgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode_q),
    .div      (div_q),
    .len      (len_q),
    .run      (state == S_RUN),
    .clear    (state == S_SETTLE),
    .pat_bit  (pat_bit),
    .last_bit (last_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; config beats start in IDLE, stop beats burst completion
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (accept)     next_state = S_LOAD;
        else if (start) next_state = S_SETTLE;
      end
      S_LOAD:  next_state = S_LATCH;
      S_LATCH: if (latch_end) next_state = S_IDLE;
      S_SETTLE: begin
        if (stop)            next_state = S_IDLE;
        else if (settle_end) next_state = S_RUN;
      end
      S_RUN: begin
        if (stop)          next_state = S_IDLE;
        else if (last_bit) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Settle and latch duration counters, cleared outside their states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      latch_cnt  <= '0;
    end else begin
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
      latch_cnt  <= (state == S_LATCH)  ? latch_cnt + 1'b1  : '0;
    end
  end

  // Configuration capture on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_SQUARE;
      div_q    <= '0;
      len_q    <= '0;
      trim_p_q <= '0;
      trim_n_q <= '0;
    end else if (accept) begin
      mode_q   <= mode_t'(cfg_mode);
      div_q    <= cfg_div;
      len_q    <= cfg_len;
      trim_p_q <= cfg_trim_p;
      trim_n_q <= cfg_trim_n;
    end
  end

  // Registered outputs; enable/signal drop on the same edge that samples stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      inj_enable <= 1'b0;
      inj_latch  <= 1'b0;
      inj_signal <= 1'b0;
      inj_trim_p <= '0;
      inj_trim_n <= '0;
    end else begin
      cfg_ready  <= (state == S_IDLE) && (next_state == S_IDLE);
      busy       <= (next_state != S_IDLE);
      done       <= (state == S_DONE);
      inj_enable <= ((state == S_SETTLE) || (state == S_RUN)) && !stop;
      inj_signal <= (state == S_RUN) && !stop && pat_bit;
      inj_latch  <= (state == S_LATCH);
      if (state == S_LOAD) begin
        inj_trim_p <= trim_p_q;
        inj_trim_n <= trim_n_q;
      end
    end
  end

endmodule
